// File: rtl/bcd_down_counter_if.sv
// Bundles the user-facing signals of bcd_down_counter.
//   load_btn : async push-button load request, active-high
//   run_sw   : async run switch, 1 = count down, 0 = hold
//   din      : BCD preset value, sampled on load
//   q        : current BCD count
//   borrow   : one-clk pulse on the 0 -> 9 wrap
//   load_err : sticky flag, last load saw an invalid BCD value
//   cloc     : divided clock, toggles on every count tick
//   state_o  : current FSM state code for debug LEDs
// master drives the controls and observes the counter; slave is the counter.
interface bcd_down_counter_if;
  logic       load_btn;
  logic       run_sw;
  logic [3:0] din;
  logic [3:0] q;
  logic       borrow;
  logic       load_err;
  logic       cloc;
  logic [1:0] state_o;

  modport master (
    output load_btn, run_sw, din,
    input  q, borrow, load_err, cloc, state_o
  );

  modport slave (
    input  load_btn, run_sw, din,
    output q, borrow, load_err, cloc, state_o
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Single-digit BCD down counter with a free-running tick divider, a
// synchronized load button (edge-detected) and run switch, and a small
// IDLE/RUN/LOAD state machine.
//   clk   : system clock, all logic on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of bcd_down_counter_if (controls in, count/status out)
module bcd_down_counter #(
  parameter int unsigned DIV_COUNT = 20000000,
  parameter int unsigned DIV_W     = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_down_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LOAD = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic             ld_s1, ld_s2, ld_prev;
  logic             rn_s1, rn_s2;
  logic             load_req;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             cloc_r;
  logic [3:0]       q_r;
  logic             borrow_r;
  logic             err_r;
  logic             load_now;
  logic             dec_now;

  // Two-flop synchronizers; ld_prev holds the previous synchronized value so a
  // held button gives exactly one request. ld_prev resets to 0, so a button
  // already held through reset still yields one request afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_s1   <= 1'b0;
      ld_s2   <= 1'b0;
      ld_prev <= 1'b0;
      rn_s1   <= 1'b0;
      rn_s2   <= 1'b0;
    end else begin
      ld_s1   <= bus.load_btn;
      ld_s2   <= ld_s1;
      ld_prev <= ld_s2;
      rn_s1   <= bus.run_sw;
      rn_s2   <= rn_s1;
    end
  end

  assign load_req = ld_s2 & ~ld_prev;

  // Free-running divider; tick is high during the wrap cycle.
  assign tick = (div == DIV_W'(DIV_COUNT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div    <= '0;
      cloc_r <= 1'b0;
    end else begin
      div    <= tick ? '0 : div + 1'b1;
      cloc_r <= cloc_r ^ tick;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (load_req)   state_nxt = LOAD;
        else if (rn_s2) state_nxt = RUN;
        else            state_nxt = IDLE;
      end
      RUN: begin
        if (load_req)    state_nxt = LOAD;
        else if (!rn_s2) state_nxt = IDLE;
        else             state_nxt = RUN;
      end
      LOAD: state_nxt = rn_s2 ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; a load request in RUN suppresses that cycle's decrement.
  always_comb begin
    load_now = (state == LOAD);
    dec_now  = (state == RUN) && tick && !load_req;
  end

  // Count datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r      <= '0;
      borrow_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      borrow_r <= 1'b0;
      if (load_now) begin
        if (bus.din > 4'd9) begin
          q_r   <= 4'd9;
          err_r <= 1'b1;
        end else begin
          q_r   <= bus.din;
          err_r <= 1'b0;
        end
      end else if (dec_now) begin
        if (q_r == 4'd0) begin
          q_r      <= 4'd9;
          borrow_r <= 1'b1;
        end else begin
          q_r <= q_r - 4'd1;
        end
      end
    end
  end

  assign bus.q        = q_r;
  assign bus.borrow   = borrow_r;
  assign bus.load_err = err_r;
  assign bus.cloc     = cloc_r;
  assign bus.state_o  = state;

endmodule
